sdf_reorder_buf: RTL

- Output stage that sits directly downstream of the last R2SDF butterfly stage.
- Accepts the bit-reversed-order complex sample stream that the butterfly stages emit, and re-emits each 2^N-point frame in natural order.
- Uses a ping-pong (two-bank) buffer, so back-to-back frames stream continuously with no stall.
- Fixed-point replacement for the real-valued bench model of the output ordering.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/sdf_pp_bank.sv | 30 +++
 rtl/sdf_reorder_buf.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, complex sample type and the bit-reversal helper used
// by the reorder logic.
package fft_pkg;

  localparam int N_DEF = 3;
  localparam int W_DEF = 16;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  // Reverse the low n bits of idx; bits at and above n are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) r[i[4:0]] = idx[5'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_pp_bank.sv
// Two-bank simple dual-port sample RAM with a registered, resettable read port
// that holds its value while the read enable is low.
module sdf_pp_bank #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic           wr_bank,
  input  logic [N-1:0]   wr_addr,
  input  logic [2*W-1:0] wr_data,
  input  logic           rd_en,
  input  logic           rd_bank,
  input  logic [N-1:0]   rd_addr,
  output logic [2*W-1:0] rd_data
);

  logic [2*W-1:0] mem [2][2**N];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/sdf_reorder_buf.sv
// Bit-reversed to natural-order reorder stage for the R2SDF pipeline, using a
// ping-pong buffer so consecutive frames stream without stalls.
module sdf_reorder_buf
  import fft_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_ip,
  input  logic [W-1:0] ip_re,
  input  logic [W-1:0] ip_im,
  output logic [W-1:0] op_re,
  output logic [W-1:0] op_im,
  output logic         op_valid,
  output logic         start_op,
  output logic         busy
);

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_WRITE = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_READ  = 1'b1;
  localparam logic [N-1:0] LAST  = '1;

  logic [0:0]     wstate, rstate;
  logic [N-1:0]   wcnt, rcnt;
  logic           wr_bank, rd_bank;
  logic [1:0]     full, set_full, clr_full;
  logic           we, wr_done, rd_done, rd_en;
  logic [N-1:0]   wr_addr;
  logic [2*W-1:0] rd_data;

  always_comb begin
    we      = 1'b0;
    wr_addr = '0;
    wr_done = 1'b0;
    case (wstate)
      W_IDLE:  we = start_ip;
      W_WRITE: begin
        we      = 1'b1;
        wr_addr = N'(bitrev(32'(wcnt), N));
        wr_done = (wcnt == LAST);
      end
      default: ;
    endcase
    rd_en    = (rstate == R_READ);
    rd_done  = rd_en && (rcnt == LAST);
    set_full = {wr_bank, ~wr_bank} & {2{wr_done}};
    clr_full = {rd_bank, ~rd_bank} & {2{rd_done}};
  end

  // Frame completion simply returns to W_IDLE, which accepts a start_ip on the
  // very next cycle, giving back-to-back frames without a dedicated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate  <= W_IDLE;
      wcnt    <= '0;
      wr_bank <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (start_ip) begin
          wstate <= W_WRITE;
          wcnt   <= N'(1);
        end
        W_WRITE: begin
          wcnt <= wcnt + N'(1);
          if (wr_done) begin
            wstate  <= W_IDLE;
            wr_bank <= ~wr_bank;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= '0;
    else        full <= (full & ~clr_full) | set_full;
  end

  // Banks fill in strict alternation, so the next bank to read is always the
  // oldest full one; a same-cycle fill of the other bank still chains reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate   <= R_IDLE;
      rcnt     <= '0;
      rd_bank  <= 1'b0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
    end else begin
      op_valid <= rd_en;
      start_op <= rd_en && (rcnt == '0);
      case (rstate)
        R_IDLE: if (full[rd_bank]) begin
          rstate <= R_READ;
          rcnt   <= '0;
        end
        R_READ: begin
          rcnt <= rcnt + N'(1);
          if (rd_done) begin
            rd_bank <= ~rd_bank;
            if (!(full[~rd_bank] || set_full[~rd_bank])) rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign busy  = (wstate != W_IDLE) || (rstate != R_IDLE) || full[0] || full[1];
  assign op_re = rd_data[2*W-1:W];
  assign op_im = rd_data[W-1:0];

  sdf_pp_bank #(.N(N), .W(W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({ip_re, ip_im}),
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .rd_addr (rcnt),
    .rd_data (rd_data)
  );

endmodule
